// File: rtl/perf_counter_if.sv
// perf_counter_if: CSR access bus between the core (master) and the counter bank (slave).
// Signals: csr_rd_en/csr_wr_en (never together), csr_addr, csr_wdata from the master;
// csr_rdata/csr_rd_valid (1 cycle after rd_en) and csr_err (unmapped access) from the slave.
interface perf_counter_if;
    logic        csr_rd_en;
    logic        csr_wr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rd_valid;
    logic        csr_err;
    modport master (output csr_rd_en, csr_wr_en, csr_addr, csr_wdata,
                    input  csr_rdata, csr_rd_valid, csr_err);
    modport slave  (input  csr_rd_en, csr_wr_en, csr_addr, csr_wdata,
                    output csr_rdata, csr_rd_valid, csr_err);
endinterface

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: cycle/instret/HPM counter bank with overflow interrupt and registered CSR port.
// Ports: clk; reset (async, active-high); freeze_i stops all counting; evt_retire_i and
// evt_vec_i are per-cycle event strobes; csr is the CSR slave port; ovf_irq_o = |(ovf_status & ovf_en).
module perf_counter_unit #(
    parameter int CNT_W = 64,
    parameter int N_HPM = 4,
    parameter int N_EVT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze_i,
    input  logic             evt_retire_i,
    input  logic [N_EVT-1:0] evt_vec_i,
    perf_counter_if.slave    csr,
    output logic             ovf_irq_o
);
    localparam int NC   = N_HPM + 3;
    localparam int ES_W = $clog2(N_EVT + 1);

    logic [CNT_W-1:0] cnt_q [NC];
    logic [CNT_W-1:0] cnt_d [NC];
    logic [ES_W-1:0]  sel_q [N_HPM];
    logic [ES_W-1:0]  sel_d [N_HPM];
    logic [NC-1:0]    inh_q, inh_d, ovf_q, ovf_d, ovf_en_q, ovf_en_d, ev, inc, ovf_set;
    logic [31:0]      shadow_q, shadow_d, rdata_q, rdata_d;
    logic [6:0]       prev_idx_q, idx;
    logic             prev_lo_q, valid_q, err_q, hit, any_en;
    logic             idx_ok, rd_lo, rd_hi, wr_lo, wr_hi, sel_hit, inh_hit, ost_hit, oen_hit;
    logic [11:0]      sel_off;

    function automatic logic [31:0] hi_of(input logic [CNT_W-1:0] c);
        return 32'({32'b0, c} >> 32);
    endfunction

    function automatic logic [CNT_W-1:0] put_half(input logic [CNT_W-1:0] c, input logic hi,
                                                  input logic [31:0] d);
        logic [63:0] w;
        w = 64'(c);
        if (hi) w[63:32] = d;
        else w[31:0] = d;
        return CNT_W'(w);
    endfunction

    // Counter index 1 is a hole in the map: never addressable, never counts.
    assign idx     = csr.csr_addr[6:0];
    assign idx_ok  = (int'(idx) < NC) && (idx != 7'd1);
    assign rd_lo   = csr.csr_rd_en && csr.csr_addr[11:7] == 5'h18 && idx_ok;
    assign rd_hi   = csr.csr_rd_en && csr.csr_addr[11:7] == 5'h19 && idx_ok;
    assign wr_lo   = csr.csr_wr_en && csr.csr_addr[11:7] == 5'h16 && idx_ok;
    assign wr_hi   = csr.csr_wr_en && csr.csr_addr[11:7] == 5'h17 && idx_ok;
    assign sel_off = csr.csr_addr - 12'h323;
    assign sel_hit = csr.csr_addr >= 12'h323 && sel_off < 12'(N_HPM);
    assign inh_hit = csr.csr_addr == 12'h320;
    assign ost_hit = csr.csr_addr == 12'h7C0;
    assign oen_hit = csr.csr_addr == 12'h7C1;
    assign any_en  = csr.csr_rd_en || csr.csr_wr_en;
    assign hit     = rd_lo || rd_hi || wr_lo || wr_hi ||
                     (any_en && (sel_hit || inh_hit || ost_hit || oen_hit));
    assign ovf_irq_o = |(ovf_q & ovf_en_q);

    always_comb begin
        ev    = '0;
        ev[0] = 1'b1;
        ev[2] = evt_retire_i;
        for (int h = 0; h < N_HPM; h++)
            for (int e = 0; e < N_EVT; e++)
                if (int'(sel_q[h]) == e + 1) ev[h+3] = evt_vec_i[e];
    end

    assign inc = freeze_i ? '0 : ev & ~inh_q;

    always_comb begin
        ovf_set  = '0;
        rdata_d  = '0;
        shadow_d = shadow_q;
        for (int i = 0; i < NC; i++) begin
            // A write owns the whole counter this cycle: no increment, no wrap.
            if ((wr_lo || wr_hi) && idx == 7'(i)) begin
                cnt_d[i] = put_half(cnt_q[i], wr_hi, csr.csr_wdata);
            end else begin
                cnt_d[i]   = cnt_q[i] + CNT_W'(inc[i]);
                ovf_set[i] = inc[i] && &cnt_q[i];
            end
            if (rd_lo && idx == 7'(i)) begin
                rdata_d  = cnt_q[i][31:0];
                shadow_d = hi_of(cnt_q[i]);
            end
            // High half comes from the snapshot only when it pairs with the previous low read.
            if (rd_hi && idx == 7'(i))
                rdata_d = (prev_lo_q && prev_idx_q == idx) ? shadow_q : hi_of(cnt_q[i]);
        end
        for (int h = 0; h < N_HPM; h++) begin
            sel_d[h] = (csr.csr_wr_en && sel_hit && sel_off == 12'(h)) ? csr.csr_wdata[ES_W-1:0] : sel_q[h];
            if (csr.csr_rd_en && sel_hit && sel_off == 12'(h)) rdata_d = 32'(sel_q[h]);
        end
        if (csr.csr_rd_en && inh_hit) rdata_d = 32'(inh_q);
        if (csr.csr_rd_en && ost_hit) rdata_d = 32'(ovf_q);
        if (csr.csr_rd_en && oen_hit) rdata_d = 32'(ovf_en_q);
        inh_d    = (csr.csr_wr_en && inh_hit) ? csr.csr_wdata[NC-1:0] & ~NC'(2) : inh_q;
        ovf_en_d = (csr.csr_wr_en && oen_hit) ? csr.csr_wdata[NC-1:0] : ovf_en_q;
        // Set after clear so a wrap in the same cycle as W1C survives.
        ovf_d    = (ovf_q & ~((csr.csr_wr_en && ost_hit) ? csr.csr_wdata[NC-1:0] : '0)) | ovf_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '{default: '0};
            sel_q      <= '{default: '0};
            inh_q      <= '0;
            ovf_q      <= '0;
            ovf_en_q   <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            prev_lo_q  <= 1'b0;
            prev_idx_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            inh_q    <= inh_d;
            ovf_q    <= ovf_d;
            ovf_en_q <= ovf_en_d;
            shadow_q <= shadow_d;
            valid_q  <= csr.csr_rd_en;
            err_q    <= any_en && !hit;
            if (csr.csr_rd_en) begin
                rdata_q    <= rdata_d;
                prev_lo_q  <= rd_lo;
                prev_idx_q <= idx;
            end
        end
    end

    assign csr.csr_rdata    = rdata_q;
    assign csr.csr_rd_valid = valid_q;
    assign csr.csr_err      = err_q;
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: directed plus randomized checks of perf_counter_unit against a counter-bank model.
module tb_perf_counter_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       freeze = 1'b0;
    logic       retire = 1'b0;
    logic [7:0] evv = '0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    perf_counter_if bus();

    perf_counter_unit dut (
        .clk         (clk),
        .reset       (reset),
        .freeze_i    (freeze),
        .evt_retire_i(retire),
        .evt_vec_i   (evv),
        .csr         (bus),
        .ovf_irq_o   (irq)
    );

    always #5 clk = ~clk;

    longint unsigned m_cnt [7];
    int unsigned     m_sel [4];
    bit [6:0]        m_inh, m_ovf, m_en;
    bit [31:0]       m_shadow;
    bit              m_prev_lo;
    int              m_prev_idx;
    bit              e_valid, e_err;
    bit [31:0]       e_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cidx(input logic [11:0] a, input logic [11:0] base);
        int off;
        off = int'(a) - int'(base);
        return (off >= 0 && off < 7 && off != 1) ? off : -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 7; k++) m_cnt[k] = 0;
        for (int h = 0; h < 4; h++) m_sel[h] = 0;
        m_inh = '0; m_ovf = '0; m_en = '0; m_shadow = '0;
        m_prev_lo = 0; m_prev_idx = 0;
        e_valid = 0; e_err = 0; e_rdata = '0;
    endtask

    task automatic model_step(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] d);
        longint unsigned old [7];
        bit [6:0] evt, set;
        bit hit;
        int i;
        old = m_cnt;
        set = '0;
        hit = 0;
        evt = '0;
        evt[0] = 1;
        evt[2] = retire;
        for (int h = 0; h < 4; h++)
            if (m_sel[h] >= 1 && m_sel[h] <= 8) evt[h+3] = evv[m_sel[h]-1];
        e_valid = rd;
        if (rd) begin
            e_rdata = '0;
            if (cidx(a, 12'hC00) >= 0) begin
                i = cidx(a, 12'hC00);
                e_rdata = old[i][31:0];
                m_shadow = old[i][63:32];
                hit = 1;
            end else if (cidx(a, 12'hC80) >= 0) begin
                i = cidx(a, 12'hC80);
                e_rdata = (m_prev_lo && m_prev_idx == i) ? m_shadow : old[i][63:32];
                hit = 1;
            end else if (a >= 12'h323 && a <= 12'h326) begin
                e_rdata = m_sel[a - 12'h323];
                hit = 1;
            end else if (a == 12'h320) begin
                e_rdata = 32'(m_inh); hit = 1;
            end else if (a == 12'h7C0) begin
                e_rdata = 32'(m_ovf); hit = 1;
            end else if (a == 12'h7C1) begin
                e_rdata = 32'(m_en); hit = 1;
            end
            m_prev_lo = cidx(a, 12'hC00) >= 0;
            m_prev_idx = cidx(a, 12'hC00);
        end
        for (int k = 0; k < 7; k++)
            if (!freeze && !m_inh[k] && evt[k]) begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == 0) set[k] = 1;
            end
        if (wr) begin
            if (cidx(a, 12'hB00) >= 0) begin
                i = cidx(a, 12'hB00);
                m_cnt[i] = {old[i][63:32], d};
                set[i] = 0;
                hit = 1;
            end else if (cidx(a, 12'hB80) >= 0) begin
                i = cidx(a, 12'hB80);
                m_cnt[i] = {d, old[i][31:0]};
                set[i] = 0;
                hit = 1;
            end else if (a >= 12'h323 && a <= 12'h326) begin
                m_sel[a - 12'h323] = d[3:0];
                hit = 1;
            end else if (a == 12'h320) begin
                m_inh = d[6:0] & 7'h7D; hit = 1;
            end else if (a == 12'h7C0) begin
                m_ovf = m_ovf & ~d[6:0]; hit = 1;
            end else if (a == 12'h7C1) begin
                m_en = d[6:0]; hit = 1;
            end
        end
        m_ovf = m_ovf | set;
        e_err = (rd || wr) && !hit;
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] d);
        bus.csr_rd_en = rd;
        bus.csr_wr_en = wr;
        bus.csr_addr = a;
        bus.csr_wdata = d;
        @(posedge clk);
        model_step(rd, wr, a, d);
        #1;
        check("rd_valid", bus.csr_rd_valid, e_valid);
        check("csr_err", bus.csr_err, e_err);
        check("ovf_irq", irq, |(m_ovf & m_en));
        if (e_valid) check($sformatf("rdata@%h", a), bus.csr_rdata, e_rdata);
        bus.csr_rd_en = 0;
        bus.csr_wr_en = 0;
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1, 0, a, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc(0, 1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    logic [11:0] addrs [$] = '{12'hC00, 12'hC02, 12'hC03, 12'hC04, 12'hC05, 12'hC06,
                               12'hC80, 12'hC82, 12'hC83, 12'hC84, 12'hC85, 12'hC86,
                               12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                               12'hB80, 12'hB83, 12'h323, 12'h324, 12'h325, 12'h326,
                               12'h320, 12'h7C0, 12'h7C1, 12'h7FF, 12'hC01, 12'h327};

    initial begin
        bit [31:0] held;
        bus.csr_rd_en = 0;
        bus.csr_wr_en = 0;
        bus.csr_addr = '0;
        bus.csr_wdata = '0;
        model_reset();
        #12;
        check("reset_rdata", bus.csr_rdata, 0);
        check("reset_valid", bus.csr_rd_valid, 0);
        check("reset_err", bus.csr_err, 0);
        check("reset_irq", irq, 0);
        @(negedge clk);
        reset = 0;

        idle(100);
        rd(12'hC00);
        check("cycle_100", bus.csr_rdata, 100);
        rd(12'hC80);
        check("cycle_hi_zero", bus.csr_rdata, 0);

        wr(12'h323, 3);
        evv = 8'h04; idle(17);
        evv = 8'h01; idle(5);
        evv = 8'h00;
        rd(12'hC03);
        check("hpm3_sel3", bus.csr_rdata, 17);
        wr(12'h323, 0);
        evv = 8'h04; idle(4);
        evv = 8'h00;
        rd(12'hC03);
        check("hpm3_sel0_hold", bus.csr_rdata, 17);

        wr(12'h320, 4);
        retire = 1; idle(10);
        retire = 0;
        rd(12'hC02);
        check("instret_inhibit", bus.csr_rdata, 0);
        wr(12'h320, 0);
        retire = 1; idle(10);
        retire = 0;
        rd(12'hC02);
        check("instret_10", bus.csr_rdata, 10);
        freeze = 1;
        rd(12'hC00);
        held = e_rdata;
        idle(3);
        rd(12'hC00);
        check("freeze_hold", bus.csr_rdata, held);
        freeze = 0;

        wr(12'h7C1, 1);
        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'hFFFF_FFFF);
        idle(2);
        check("ovf_irq_set", irq, 1);
        rd(12'hC00);
        check("wrap_zero", bus.csr_rdata, 0);
        rd(12'h7C0);
        check("ovf_status0", bus.csr_rdata, 1);
        wr(12'h7C0, 1);
        check("irq_cleared", irq, 0);

        wr(12'hB80, 5);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hC00);
        check("tear_lo", bus.csr_rdata, 32'hFFFF_FFFF);
        rd(12'hC80);
        check("tear_free_hi", bus.csr_rdata, 5);
        rd(12'hC80);
        check("live_hi", bus.csr_rdata, 6);

        wr(12'h323, 1);
        evv = 8'h01;
        wr(12'hB03, 32'h1234);
        evv = 8'h00;
        rd(12'hC03);
        check("write_beats_inc", bus.csr_rdata, 32'h1234);
        rd(12'h7FF);
        check("unmapped_rdata", bus.csr_rdata, 0);
        check("unmapped_err", bus.csr_err, 1);
        idle(1);
        check("err_pulse_end", bus.csr_err, 0);

        for (int n = 0; n < 800; n++) begin
            logic [11:0] a;
            logic [31:0] d;
            int r;
            freeze = $urandom_range(7) == 0;
            retire = 1'($urandom_range(1));
            evv = 8'($urandom);
            a = addrs[$urandom_range(addrs.size() - 1)];
            d = ($urandom_range(2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            r = $urandom_range(9);
            if (r < 4) rd(a);
            else if (r < 6) wr(a, d);
            else idle(1);
        end
        freeze = 0; retire = 0; evv = '0;

        rd(12'hC00);
        check("valid_before_reset", bus.csr_rd_valid, 1);
        reset = 1;
        #1;
        check("reset_mid_valid", bus.csr_rd_valid, 0);
        check("reset_mid_rdata", bus.csr_rdata, 0);
        check("reset_mid_irq", irq, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        rd(12'hC00);
        check("post_reset_cycle", bus.csr_rdata, 0);
        rd(12'hC00);
        check("post_reset_count", bus.csr_rdata, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
Parametrised hardware performance-monitor block for the torv32 pipeline family. It generalises the core's fixed 64-bit cycle/instret pair into a counter bank. The bank holds cycle, instret and N_HPM programmable event counters of width CNT_W. It adds per-counter inhibit, event selection, overflow flags with interrupt, global freeze, and a registered 32-bit CSR read/write port. It sits beside the writeback stage; the core drives event strobes and CSR accesses into it.

Parameters:
CNT_W, 64, counter width; legal range 32..64.
N_HPM, 4, number of programmable counters hpm3..hpm(2+N_HPM); legal range 1..29.
N_EVT, 8, number of event inputs; selector width ES_W = clog2(N_EVT+1).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
freeze  in  1  high = no counter increments (driven by halt/EBREAK)
evt_retire  in  1  one instruction retired this cycle
evt_vec  in  N_EVT  per-cycle event strobes
csr_rd_en  in  1  read request
csr_wr_en  in  1  write request; rd_en and wr_en never assert together
csr_addr  in  12  CSR address
csr_wdata  in  32  write data
csr_rdata  out  32  read data, valid when csr_rd_valid
csr_rd_valid  out  1  one-cycle pulse, 1 cycle after csr_rd_en
csr_err  out  1  one-cycle pulse, 1 cycle after an access to an unmapped address
ovf_irq  out  1  OR of (ovf_status & ovf_en)

Behaviour:
- Reset (async, active-high): all counters, event selectors, inhibit, ovf_status, ovf_en and shadow regs = 0. Outputs csr_rdata, csr_rd_valid, csr_err and ovf_irq = 0.
- Counter index i: 0 = cycle, 2 = instret, 3..2+N_HPM = hpm. Index 1 is unmapped.
- Increment: counter i adds 1 when !freeze, !inhibit[i] and its event is high.
  - Event for cycle is constant 1.
  - Event for instret is evt_retire.
  - Event for hpm is evt_vec[sel-1], where sel is the counter's selector. sel = 0 or sel > N_EVT never counts.
- Arithmetic is modulo 2^CNT_W. When a counter goes from all-ones to 0, ovf_status[i] is set and stays set.
- Address map (unmapped address: write ignored, read returns 0 and pulses csr_err):
  - 0xC00+i: read low 32 bits.
  - 0xC80+i: read high bits [CNT_W-1:32], zero-extended; reads 0 when CNT_W=32.
  - 0xB00+i / 0xB80+i: write low / high half.
  - 0x323+(i-3): hpm event selector, R/W, low ES_W bits used.
  - 0x320: inhibit mask, R/W; bit i maps to counter i, bit 1 reads 0.
  - 0x7C0: ovf_status; reads status, write-1-to-clear.
  - 0x7C1: ovf_en, R/W.
- Read latency: 1 cycle. csr_rdata and csr_rd_valid are registered. csr_rdata holds its value when no read is in progress.
- Tear-free 64-bit read:
  - A read of 0xC00+i copies counter i bits [CNT_W-1:32], as of the same cycle, into shadow_hi.
  - A read of 0xC80+i returns shadow_hi if the immediately preceding read was 0xC00+i; otherwise it returns live high bits.
  - One shadow register is shared by all counters.
- Simultaneous write and increment on the same counter: the written value is taken; no increment that cycle. The untouched half keeps its current value, without increment.
- Simultaneous overflow set and W1C clear on the same bit: set wins.
- Writing a counter to all-ones does not set overflow; only an increment-driven wrap sets it.
- freeze asserted mid-operation: counts stop next edge. CSR reads and writes continue normally.
- Reset mid-read: csr_rd_valid is cleared immediately; the pending read is lost.

Test Plan:
- Reset then release, run 100 cycles, read 0xC00 -> rdata = 100 (±1 per bench alignment rule), valid 1 cycle after rd_en. Read 0xC80 -> 0.
- Write 0x323 = 3, pulse evt_vec[2] 17 times and evt_vec[0] 5 times, read 0xC03 -> 17. Write selector 0 -> counter holds.
- Write inhibit 0x320 = 0x4, assert evt_retire 10 cycles, read 0xC02 -> 0. Clear inhibit, 10 retires -> 10. Hold freeze and read cycle twice -> equal values.
- CNT_W=64: write 0xB00 = 0xFFFFFFFE and 0xB80 = 0xFFFFFFFF, ovf_en = 0x1, wait 2 cycles -> ovf_status[0] = 1, ovf_irq = 1, counter = 0. Write 0x7C0 = 1 -> irq drops next cycle.
- Cycle low = 0xFFFFFFFF with high = 5: read 0xC00, then read 0xC80 after the carry -> returns 5, not 6. Read 0xC80 without a preceding 0xC00 -> 6.
- Write 0xB03 = 0x1234 in the same cycle as a selected event, and read 0x7FF -> counter = 0x1234. The 0x7FF read returns rdata 0 and a 1-cycle csr_err pulse.
